pattern_step_sequencer: RTL and testbench
=========================================

// Module: pattern_step_sequencer
// PURPOSE
//   Parametrised multi-channel drum step sequencer. Sits behind the SoC's 32-bit pattern PIO.
//   Holds a double-buffered pattern: NUM_CH channels x NUM_STEPS steps. New patterns swap in only
//   at bar boundaries, so playback never glitches mid-bar. Emits one-cycle per-channel triggers at a
//   programmable step rate. Adds per-channel mute and bar/step status for LEDs and hex digits.
// PARAMETERS
//   NUM_CH     4   number of voice channels (trigger outputs)
//   NUM_STEPS  8   steps per bar; power of two, >=2
//   TDIV_W     24  width of tempo divider (clock cycles per step)
//   STEP_W     $clog2(NUM_STEPS), localparam, width of step index
// PORTS
//   clk_clk        in   1                  system clock
//   reset_reset_n  in   1                  asynchronous active-low reset
//   pattern_word   in   NUM_CH*NUM_STEPS   pattern; bit [ch*NUM_STEPS+step] = channel ch fires at step
//   pattern_load   in   1                  1-cycle strobe: capture pattern_word into shadow buffer
//   tempo_div      in   TDIV_W             clock cycles per step; 0 is treated as 1
//   run            in   1                  level: 1 = play, 0 = stop
//   mute           in   NUM_CH             per-channel trigger mask; 1 = suppress
//   trig           out  NUM_CH             1-cycle trigger pulses for the current step
//   step_idx       out  STEP_W             step currently playing
//   bar_pulse      out  1                  1-cycle pulse when step 0 fires
//   pending        out  1                  shadow holds a pattern not yet swapped in
//   running        out  1                  FSM is in RUN
// BEHAVIOUR
//   Reset (async assert, sync release)
//     - active, shadow, tempo counter, step_idx = 0
//     - trig = 0, bar_pulse = 0, pending = 0, running = 0; FSM = IDLE
//   FSM: IDLE <-> RUN
//     - IDLE -> RUN when run=1 is sampled. In the next cycle: step 0 fires (trig, bar_pulse),
//       running=1, tempo counter=0. Latency from run to first trig is 1 cycle.
//     - RUN -> IDLE when run=0 is sampled. Next cycle: trig=0, bar_pulse=0, step_idx=0,
//       counter=0, running=0. No trigger fires on stop.
//   Tempo counter (RUN only)
//     - Increments each cycle.
//     - When counter >= max(tempo_div,1)-1: counter <= 0, step_idx <= step_idx+1 (mod NUM_STEPS),
//       and the new step fires.
//     - The >= compare means a lowered tempo_div takes effect at once, with no counter wrap-around.
//   Firing a step s
//     - trig[ch] = active[ch*NUM_STEPS+s] & ~mute[ch] for exactly 1 cycle; otherwise trig = 0.
//     - bar_pulse = (s==0).
//     - tempo_div=1: a step fires every cycle, so trig may stay high across consecutive cycles.
//   Pattern buffering
//     - pattern_load: shadow <= pattern_word, pending <= 1.
//     - Swap (active <= shadow, pending <= 0) happens in the cycle where step 0 is about to fire:
//       the IDLE->RUN transition, or wrap from NUM_STEPS-1 to 0.
//     - In IDLE with pending=1: swap on the next cycle. A stopped sequencer always holds the latest pattern.
//     - pattern_load in the same cycle as a swap: pattern_word bypasses the shadow straight into
//       active, pending <= 0. Step 0 fires with the new word.
//     - A second load before a swap overwrites the shadow; the last load wins.
//   mute is sampled combinationally at fire time and is not buffered.
//   No X on outputs after reset. All outputs are registered.
// TESTING (NUM_CH=4, NUM_STEPS=8)
//   - Reset mid-RUN with trig active -> all outputs 0 immediately. After release: IDLE, step_idx=0.
//   - Load 0x0000_0011 (ch0 steps 0,4), tempo_div=4, run=1 -> trig=4'b0001 at cycle 1 and every
//     16 cycles after; bar_pulse every 32 cycles; step_idx advances every 4 cycles.
//   - Running 0x01, load 0x0000_0100 at step 3 -> pending=1; step-0 triggers still follow the old
//     pattern for the rest of the bar; at wrap, ch1 fires on step 0 and pending=0.
//   - pattern_load in the swap cycle -> new word plays on that step 0; pending stays 0.
//   - mute=4'b0001 with ch0 pattern 0xFF -> trig[0] never asserts; unmute -> fires on the next step.
//   - tempo_div changes 8->2 while counter=5 -> next step fires the next cycle.
//   - tempo_div=0 -> one step per cycle.
//   - run drop at step 5 -> no trig, step_idx=0. run re-raised -> step 0 fires 1 cycle later.

Source files
------------

// File: rtl/pattern_step_sequencer_if.sv
// ============================================================================
// Module   : pattern_step_sequencer_if
// Purpose  : Pattern PIO bundle between the SoC master and the step sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface pattern_step_sequencer_if #(
  parameter int NUM_CH    = 4,
  parameter int NUM_STEPS = 8,
  parameter int TDIV_W    = 24
);
  localparam int STEP_W = $clog2(NUM_STEPS);

  logic [NUM_CH*NUM_STEPS-1:0] pattern_word;
  logic                        pattern_load;
  logic [TDIV_W-1:0]           tempo_div;
  logic                        run;
  logic [NUM_CH-1:0]           mute;
  logic [NUM_CH-1:0]           trig;
  logic [STEP_W-1:0]           step_idx;
  logic                        bar_pulse;
  logic                        pending;
  logic                        running;

  modport master (
    output pattern_word, pattern_load, tempo_div, run, mute,
    input  trig, step_idx, bar_pulse, pending, running
  );

  modport slave (
    input  pattern_word, pattern_load, tempo_div, run, mute,
    output trig, step_idx, bar_pulse, pending, running
  );
endinterface

`default_nettype wire

// File: rtl/pattern_step_sequencer.sv
// ============================================================================
// Module   : pattern_step_sequencer
// Purpose  : Multi-channel drum step sequencer with a bar-aligned double-buffered pattern.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pattern_step_sequencer #(
  parameter int NUM_CH    = 4,
  parameter int NUM_STEPS = 8,
  parameter int TDIV_W    = 24
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  pattern_step_sequencer_if.slave  bus
);

  localparam int STEP_W = $clog2(NUM_STEPS);
  localparam int PAT_W  = NUM_CH * NUM_STEPS;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [STEP_W-1:0] c_LAST_STEP = STEP_W'(NUM_STEPS - 1);

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;

  logic [PAT_W-1:0]  r_active;
  logic [PAT_W-1:0]  r_shadow;
  logic              r_pending;
  logic [TDIV_W-1:0] r_cnt;
  logic [STEP_W-1:0] r_step;
  logic [NUM_CH-1:0] r_trig;
  logic              r_bar;

  logic [PAT_W-1:0]  w_active_nxt;
  logic [PAT_W-1:0]  w_shadow_nxt;
  logic              w_pending_nxt;
  logic [TDIV_W-1:0] w_cnt_nxt;
  logic [STEP_W-1:0] w_step_nxt;
  logic [NUM_CH-1:0] w_trig_nxt;
  logic              w_bar_nxt;
  logic              w_fire;
  logic [STEP_W-1:0] w_fire_step;
  logic              w_swap_pt;
  logic [TDIV_W-1:0] w_div_m1;
  logic [NUM_CH-1:0] w_hit;

  // A tempo of zero behaves as one cycle per step.
  assign w_div_m1 = (bus.tempo_div == '0) ? '0 : (bus.tempo_div - TDIV_W'(1));

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.run)  w_state_nxt = S_RUN;
      S_RUN:   if (!bus.run) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Step timing: which step (if any) fires on the coming edge, and whether
  // that edge is a bar boundary where the shadow may replace the active pattern.
  always_comb begin
    w_fire      = 1'b0;
    w_fire_step = r_step;
    w_cnt_nxt   = r_cnt;
    w_step_nxt  = r_step;
    w_swap_pt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt  = '0;
        w_step_nxt = '0;
        if (bus.run) begin
          w_fire      = 1'b1;
          w_fire_step = '0;
          w_swap_pt   = 1'b1;
        end else begin
          w_swap_pt = r_pending;
        end
      end
      S_RUN: begin
        if (!bus.run) begin
          w_cnt_nxt  = '0;
          w_step_nxt = '0;
        end else if (r_cnt >= w_div_m1) begin
          // >= rather than == so a lowered tempo takes effect without wrapping
          w_cnt_nxt   = '0;
          w_step_nxt  = r_step + STEP_W'(1);
          w_fire      = 1'b1;
          w_fire_step = r_step + STEP_W'(1);
          w_swap_pt   = (r_step == c_LAST_STEP);
        end else begin
          w_cnt_nxt = r_cnt + TDIV_W'(1);
        end
      end
      default: begin
        w_cnt_nxt  = '0;
        w_step_nxt = '0;
      end
    endcase
  end

  always_comb begin
    w_active_nxt  = r_active;
    w_shadow_nxt  = r_shadow;
    w_pending_nxt = r_pending;
    if (w_swap_pt && bus.pattern_load) begin
      // Load coinciding with a swap goes straight to the active buffer.
      w_active_nxt  = bus.pattern_word;
      w_shadow_nxt  = bus.pattern_word;
      w_pending_nxt = 1'b0;
    end else if (w_swap_pt && r_pending) begin
      w_active_nxt  = r_shadow;
      w_pending_nxt = 1'b0;
    end else if (bus.pattern_load) begin
      w_shadow_nxt  = bus.pattern_word;
      w_pending_nxt = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [NUM_STEPS-1:0] w_row;
    assign w_row    = w_active_nxt[g*NUM_STEPS +: NUM_STEPS];
    assign w_hit[g] = w_row[w_fire_step];
  end

  always_comb begin
    w_trig_nxt = '0;
    w_bar_nxt  = 1'b0;
    if (w_fire) begin
      w_trig_nxt = w_hit & ~bus.mute;
      w_bar_nxt  = (w_fire_step == '0);
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_active  <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_cnt     <= '0;
      r_step    <= '0;
      r_trig    <= '0;
      r_bar     <= 1'b0;
    end else begin
      r_active  <= w_active_nxt;
      r_shadow  <= w_shadow_nxt;
      r_pending <= w_pending_nxt;
      r_cnt     <= w_cnt_nxt;
      r_step    <= w_step_nxt;
      r_trig    <= w_trig_nxt;
      r_bar     <= w_bar_nxt;
    end
  end

  assign bus.trig      = r_trig;
  assign bus.step_idx  = r_step;
  assign bus.bar_pulse = r_bar;
  assign bus.pending   = r_pending;
  assign bus.running   = (r_state == S_RUN);

endmodule

`default_nettype wire

// File: tb/tb_pattern_step_sequencer.sv
// ============================================================================
// Module   : tb_pattern_step_sequencer
// Purpose  : Vector table, corner sequences and random run against a reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pattern_step_sequencer;

  logic clk_clk = 1'b0;
  logic reset_reset_n;

  pattern_step_sequencer_if #(.NUM_CH(4), .NUM_STEPS(8), .TDIV_W(24)) bus ();

  pattern_step_sequencer #(.NUM_CH(4), .NUM_STEPS(8), .TDIV_W(24)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .bus           (bus)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct {
    logic        run;
    logic        load;
    logic [31:0] word;
    logic [23:0] tempo;
    logic [3:0]  mute;
    logic [3:0]  e_trig;
    logic [2:0]  e_step;
    logic        e_bar;
    logic        e_pend;
    logic        e_run;
  } vec_t;

  vec_t tbl [15];

  int n_vec = 0;
  int n_err = 0;

  // Reference model: playback position in plain integers, patterns as words.
  bit          m_playing;
  int          m_cnt;
  int          m_step;
  logic [31:0] m_active;
  logic [31:0] m_shadow;
  bit          m_pending;
  logic [3:0]  m_trig;
  bit          m_bar;

  task automatic model_reset();
    m_playing = 0; m_cnt = 0; m_step = 0;
    m_active = '0; m_shadow = '0; m_pending = 0;
    m_trig = '0; m_bar = 0;
  endtask

  task automatic model_clock(input bit run, input bit load, input logic [31:0] word,
                             input int tempo, input logic [3:0] mute);
    int div;
    int fire;
    bit was;
    bit swap;
    div  = (tempo == 0) ? 1 : tempo;
    fire = -1;
    was  = m_playing;
    if (!m_playing) begin
      if (run) begin
        m_playing = 1; m_cnt = 0; m_step = 0; fire = 0;
      end
    end else if (!run) begin
      m_playing = 0; m_cnt = 0; m_step = 0;
    end else if (m_cnt >= div - 1) begin
      m_cnt  = 0;
      m_step = (m_step + 1) % 8;
      fire   = m_step;
    end else begin
      m_cnt++;
    end
    swap = (fire == 0) || (!was && m_pending);
    if (swap && load) begin
      m_active = word; m_pending = 0;
    end else if (swap && m_pending) begin
      m_active = m_shadow; m_pending = 0;
    end else if (load) begin
      m_shadow = word; m_pending = 1;
    end
    m_trig = '0;
    m_bar  = (fire == 0);
    if (fire >= 0)
      for (int ch = 0; ch < 4; ch++)
        m_trig[ch] = m_active[ch*8 + fire] & ~mute[ch];
  endtask

  function automatic logic [9:0] dut_pack();
    return {bus.trig, bus.step_idx, bus.bar_pulse, bus.pending, bus.running};
  endfunction

  function automatic logic [9:0] model_pack();
    return {m_trig, 3'(m_step), m_bar, m_pending, m_playing};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic apply(input bit run, input bit load, input logic [31:0] word,
                       input int tempo, input logic [3:0] mute);
    @(negedge clk_clk);
    bus.run          = run;
    bus.pattern_load = load;
    bus.pattern_word = word;
    bus.tempo_div    = 24'(tempo);
    bus.mute         = mute;
    @(posedge clk_clk);
    model_clock(run, load, word, tempo, mute);
    #1;
    check("model {trig,step,bar,pend,run}", {22'd0, dut_pack()}, {22'd0, model_pack()});
  endtask

  initial begin
    bit          rrun;
    bit          rload;
    logic [31:0] rword;
    int          rtempo;
    logic [3:0]  rmute;

    //            run  load word        tempo  mute  trig  step bar pend run
    tbl[0]  = '{1'b0, 1'b1, 32'h211, 24'd2, 4'h0, 4'h0, 3'd0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,   24'd2, 4'h0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 32'h0,   24'd2, 4'h0, 4'h1, 3'd0, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 32'h0,   24'd2, 4'h0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,   24'd2, 4'h0, 4'h2, 3'd1, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 32'h0,   24'd2, 4'h0, 4'h0, 3'd1, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 32'h0,   24'd2, 4'h0, 4'h0, 3'd2, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 32'h0,   24'd2, 4'h0, 4'h0, 3'd2, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,   24'd2, 4'h0, 4'h0, 3'd3, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 32'h0,   24'd2, 4'h0, 4'h0, 3'd3, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 32'h0,   24'd2, 4'h1, 4'h0, 3'd4, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 32'h0,   24'd2, 4'h0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 32'h0,   24'd0, 4'h0, 4'h1, 3'd0, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 32'h0,   24'd0, 4'h0, 4'h2, 3'd1, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 32'h0,   24'd0, 4'h0, 4'h0, 3'd2, 1'b0, 1'b0, 1'b1};

    reset_reset_n    = 1'b0;
    bus.run          = 1'b0;
    bus.pattern_load = 1'b0;
    bus.pattern_word = '0;
    bus.tempo_div    = '0;
    bus.mute         = '0;
    model_reset();
    repeat (2) @(posedge clk_clk);
    #1;
    check("reset outputs", {22'd0, dut_pack()}, 32'd0);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      apply(tbl[i].run, tbl[i].load, tbl[i].word, int'(tbl[i].tempo), tbl[i].mute);
      check($sformatf("table vec%0d", i), {22'd0, dut_pack()},
            {22'd0, tbl[i].e_trig, tbl[i].e_step, tbl[i].e_bar, tbl[i].e_pend, tbl[i].e_run});
    end

    // Load in the IDLE->RUN swap cycle, then again in the wrap swap cycle.
    apply(0, 0, 0, 1, 4'h0);
    apply(1, 1, 32'h01, 1, 4'h0);
    check("swap-load start trig", {28'd0, bus.trig}, 32'h1);
    check("swap-load start pending", {31'd0, bus.pending}, 32'd0);
    repeat (7) apply(1, 0, 0, 1, 4'h0);
    apply(1, 1, 32'h100, 1, 4'h0);
    check("swap-load wrap trig", {28'd0, bus.trig}, 32'h2);
    check("swap-load wrap pending", {31'd0, bus.pending}, 32'd0);

    // Mid-bar load waits for the bar boundary.
    repeat (3) apply(1, 0, 0, 1, 4'h0);
    apply(1, 1, 32'h01, 1, 4'h0);
    check("mid-bar pending", {31'd0, bus.pending}, 32'd1);
    repeat (3) apply(1, 0, 0, 1, 4'h0);
    check("pending held in bar", {31'd0, bus.pending}, 32'd1);
    apply(1, 0, 0, 1, 4'h0);
    check("new pattern at wrap", {28'd0, bus.trig}, 32'h1);
    check("pending cleared at wrap", {31'd0, bus.pending}, 32'd0);

    // Mute suppresses channel 0, unmute fires on the next step.
    apply(0, 1, 32'hFF, 1, 4'h0);
    for (int i = 0; i < 4; i++) begin
      apply(1, 0, 0, 1, 4'h1);
      check("muted ch0", {31'd0, bus.trig[0]}, 32'd0);
    end
    apply(1, 0, 0, 1, 4'h0);
    check("unmuted ch0", {31'd0, bus.trig[0]}, 32'd1);

    // Lowering tempo from 8 to 2 with the counter at 5.
    apply(0, 0, 0, 8, 4'h0);
    apply(1, 0, 0, 8, 4'h0);
    repeat (5) apply(1, 0, 0, 8, 4'h0);
    check("slow tempo still step0", {29'd0, bus.step_idx}, 32'd0);
    apply(1, 0, 0, 2, 4'h0);
    check("tempo drop advances", {29'd0, bus.step_idx}, 32'd1);

    // Stop at step 5, restart.
    apply(0, 0, 0, 1, 4'h0);
    apply(1, 0, 0, 1, 4'h0);
    repeat (5) apply(1, 0, 0, 1, 4'h0);
    check("at step5", {29'd0, bus.step_idx}, 32'd5);
    apply(0, 0, 0, 1, 4'h0);
    check("stop outputs", {22'd0, dut_pack()}, 32'd0);
    apply(1, 0, 0, 1, 4'h0);
    check("restart bar_pulse", {31'd0, bus.bar_pulse}, 32'd1);
    check("restart running", {31'd0, bus.running}, 32'd1);

    rrun = 1; rtempo = 2; rmute = '0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) rrun = !rrun;
      rload = ($urandom_range(0, 11) == 0);
      rword = $urandom;
      if ($urandom_range(0, 49) == 0) rtempo = $urandom_range(0, 5);
      if ($urandom_range(0, 29) == 0) rmute = 4'($urandom);
      apply(rrun, rload, rword, rtempo, rmute);
    end

    // Asynchronous reset while triggers are active.
    apply(0, 1, 32'hFFFF_FFFF, 1, 4'h0);
    repeat (3) apply(1, 0, 0, 1, 4'h0);
    check("trig active before reset", {28'd0, bus.trig}, 32'hF);
    reset_reset_n = 1'b0;
    #1;
    check("async reset outputs", {22'd0, dut_pack()}, 32'd0);
    model_reset();
    @(posedge clk_clk);
    #1;
    check("held reset outputs", {22'd0, dut_pack()}, 32'd0);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    apply(0, 0, 0, 1, 4'h0);
    check("idle after reset", {22'd0, dut_pack()}, 32'd0);
    apply(1, 0, 0, 1, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
